dispatch_queue: RTL

- Parametrised circular instruction buffer between the decode/rename stage and the reservation-station-free functional units.
- Accepts up to ENQ_W renamed instructions per cycle, tracks operand readiness by ROB tag, and captures broadcast results from CDB_W wakeup buses.
- Dispatches in program order, up to DEQ_W per cycle, to NUM_FXU fixed-point units, one LSU and one branch unit, honouring per-unit full signals.

---
 rtl/dispatch_queue_if.sv | 55 +++++
 rtl/dispatch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: enqueue lanes, CDB wakeup buses and per-unit dispatch ports of dispatch_queue.
interface dispatch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int ENQ_W   = 4,
  parameter int NUM_FXU = 2,
  parameter int CDB_W   = 2,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 4,
  parameter int IMM_W   = 8
);
  logic                        flush;
  logic [ENQ_W-1:0]            enq_valid;
  logic [2*ENQ_W-1:0]          enq_class_flat;
  logic [OPC_W*ENQ_W-1:0]      enq_opcode_flat;
  logic [IMM_W*ENQ_W-1:0]      enq_imm_flat;
  logic [TAG_W*ENQ_W-1:0]      enq_rob_idx_flat;
  logic [ENQ_W-1:0]            enq_a_ready, enq_b_ready;
  logic [TAG_W*ENQ_W-1:0]      enq_a_tag_flat, enq_b_tag_flat;
  logic [DATA_W*ENQ_W-1:0]     enq_a_value_flat, enq_b_value_flat;
  logic [$clog2(ENQ_W+1)-1:0]  enq_credit;
  logic [CDB_W-1:0]            cdb_valid;
  logic [TAG_W*CDB_W-1:0]      cdb_tag_flat;
  logic [DATA_W*CDB_W-1:0]     cdb_value_flat;
  logic [NUM_FXU-1:0]          fxu_full;
  logic                        lsu_full, bru_full;
  logic [NUM_FXU-1:0]          fxu_valid;
  logic [TAG_W*NUM_FXU-1:0]    fxu_rob_idx_flat;
  logic [OPC_W*NUM_FXU-1:0]    fxu_opcode_flat;
  logic [IMM_W*NUM_FXU-1:0]    fxu_imm_flat;
  logic [DATA_W*NUM_FXU-1:0]   fxu_a_flat, fxu_b_flat;
  logic                        lsu_valid, bru_valid;
  logic [TAG_W-1:0]            lsu_rob_idx, bru_rob_idx;
  logic [OPC_W-1:0]            lsu_opcode, bru_opcode;
  logic [IMM_W-1:0]            lsu_imm, bru_imm;
  logic [DATA_W-1:0]           lsu_a, lsu_b, bru_a, bru_b;
  logic [$clog2(DEPTH+1)-1:0]  count;
  logic                        overflow_err;
  modport master (
    output flush, enq_valid, enq_class_flat, enq_opcode_flat, enq_imm_flat, enq_rob_idx_flat,
           enq_a_ready, enq_b_ready, enq_a_tag_flat, enq_b_tag_flat, enq_a_value_flat, enq_b_value_flat,
           cdb_valid, cdb_tag_flat, cdb_value_flat, fxu_full, lsu_full, bru_full,
    input  enq_credit, fxu_valid, fxu_rob_idx_flat, fxu_opcode_flat, fxu_imm_flat, fxu_a_flat, fxu_b_flat,
           lsu_valid, lsu_rob_idx, lsu_opcode, lsu_imm, lsu_a, lsu_b,
           bru_valid, bru_rob_idx, bru_opcode, bru_imm, bru_a, bru_b, count, overflow_err
  );
  modport slave (
    input  flush, enq_valid, enq_class_flat, enq_opcode_flat, enq_imm_flat, enq_rob_idx_flat,
           enq_a_ready, enq_b_ready, enq_a_tag_flat, enq_b_tag_flat, enq_a_value_flat, enq_b_value_flat,
           cdb_valid, cdb_tag_flat, cdb_value_flat, fxu_full, lsu_full, bru_full,
    output enq_credit, fxu_valid, fxu_rob_idx_flat, fxu_opcode_flat, fxu_imm_flat, fxu_a_flat, fxu_b_flat,
           lsu_valid, lsu_rob_idx, lsu_opcode, lsu_imm, lsu_a, lsu_b,
           bru_valid, bru_rob_idx, bru_opcode, bru_imm, bru_a, bru_b, count, overflow_err
  );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue: circular in-order dispatch buffer with CDB wakeup feeding FXU/LSU/BRU units.
// Define CDB_BYPASS_EN to let a same-cycle CDB broadcast satisfy dispatch eligibility.
module dispatch_queue #(
  parameter int DEPTH   = 8,
  parameter int ENQ_W   = 4,
  parameter int DEQ_W   = 2,
  parameter int NUM_FXU = 2,
  parameter int CDB_W   = 2,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 4,
  parameter int IMM_W   = 8
) (
  input logic clk,
  input logic rst_n,
  dispatch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(ENQ_W + 1);
  typedef struct packed {
    logic v;
    logic [1:0] cls;
    logic [OPC_W-1:0] opc;
    logic [IMM_W-1:0] imm;
    logic [TAG_W-1:0] rob;
    logic a_rdy, b_rdy;
    logic [TAG_W-1:0] a_tag, b_tag;
    logic [DATA_W-1:0] a_val, b_val;
  } ent_t;
  typedef struct packed {
    logic v;
    logic [TAG_W-1:0] rob;
    logic [OPC_W-1:0] opc;
    logic [IMM_W-1:0] imm;
    logic [DATA_W-1:0] a, b;
  } out_t;
  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];
  out_t fxu_q [NUM_FXU];
  out_t fxu_d [NUM_FXU];
  out_t lsu_q, lsu_d, bru_q, bru_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic [KW-1:0] credit;
  logic [CDB_W-1:0] cdb_v;
  logic [CDB_W*TAG_W-1:0] cdb_t;
  logic [CDB_W*DATA_W-1:0] cdb_d;
  assign cdb_v = q.cdb_valid;
  assign cdb_t = q.cdb_tag_flat;
  assign cdb_d = q.cdb_value_flat;
  assign credit = (count_q > CW'(DEPTH - ENQ_W)) ? KW'(CW'(DEPTH) - count_q) : KW'(ENQ_W);
  // {hit, value}; scanning downward lets the lowest-numbered bus win on duplicate tags
  function automatic logic [DATA_W:0] cdb_hit(input logic [TAG_W-1:0] tag);
    cdb_hit = '0;
    for (int j = CDB_W - 1; j >= 0; j--)
      if (cdb_v[j] && cdb_t[j*TAG_W +: TAG_W] == tag) cdb_hit = {1'b1, cdb_d[j*DATA_W +: DATA_W]};
  endfunction
  always_comb begin
    logic [DATA_W:0] ha, hb;
    logic [PW-1:0] idx, slot;
    logic [NUM_FXU-1:0] fxu_used;
    logic lsu_used, bru_used, stop, run, ar, br, ok;
    logic [DATA_W-1:0] av, bv;
    logic [CW-1:0] k, n;
    int fsel;
    ent_t e;
    out_t o;
    ha = '0; hb = '0; idx = '0; slot = '0; fxu_used = '0; lsu_used = 1'b0; bru_used = 1'b0;
    stop = 1'b0; run = 1'b1; ar = 1'b0; br = 1'b0; ok = 1'b0; av = '0; bv = '0;
    k = '0; n = '0; fsel = NUM_FXU; e = '0; o = '0;
    ent_d = ent_q;
    ovf_d = ovf_q;
    fxu_d = fxu_q;
    lsu_d = lsu_q;
    bru_d = bru_q;
    for (int f = 0; f < NUM_FXU; f++) fxu_d[f].v = 1'b0;
    lsu_d.v = 1'b0;
    bru_d.v = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      ha = cdb_hit(ent_q[s].a_tag);
      hb = cdb_hit(ent_q[s].b_tag);
      if (ent_q[s].v && !ent_q[s].a_rdy && ha[DATA_W]) begin ent_d[s].a_rdy = 1'b1; ent_d[s].a_val = ha[DATA_W-1:0]; end
      if (ent_q[s].v && !ent_q[s].b_rdy && hb[DATA_W]) begin ent_d[s].b_rdy = 1'b1; ent_d[s].b_val = hb[DATA_W-1:0]; end
    end
    // strict program order: the first ineligible entry blocks every younger one
    for (int w = 0; w < DEQ_W; w++) begin
      idx = head_q + PW'(w);
      e = ent_q[idx];
`ifdef CDB_BYPASS_EN
      ha = cdb_hit(e.a_tag);
      hb = cdb_hit(e.b_tag);
      ar = e.a_rdy | ha[DATA_W];
      br = e.b_rdy | hb[DATA_W];
      av = e.a_rdy ? e.a_val : ha[DATA_W-1:0];
      bv = e.b_rdy ? e.b_val : hb[DATA_W-1:0];
`else
      ar = e.a_rdy;
      br = e.b_rdy;
      av = e.a_val;
      bv = e.b_val;
`endif
      fsel = NUM_FXU;
      for (int f = NUM_FXU - 1; f >= 0; f--) if (!q.fxu_full[f] && !fxu_used[f]) fsel = f;
      ok = e.cls == 2'd0 ? fsel < NUM_FXU : e.cls == 2'd1 ? !(q.lsu_full || lsu_used) :
           e.cls == 2'd2 ? !(q.bru_full || bru_used) : 1'b0;
      stop = stop || !(e.v && ar && br && ok);
      o = '{v: 1'b1, rob: e.rob, opc: e.opc, imm: e.imm, a: av, b: bv};
      if (!stop) begin
        ent_d[idx].v = 1'b0;
        n = n + 1'b1;
        for (int f = 0; f < NUM_FXU; f++) if (e.cls == 2'd0 && f == fsel) begin fxu_d[f] = o; fxu_used[f] = 1'b1; end
        if (e.cls == 2'd1) begin lsu_d = o; lsu_used = 1'b1; end
        if (e.cls == 2'd2) begin bru_d = o; bru_used = 1'b1; end
      end
    end
    for (int i = 0; i < ENQ_W; i++) begin
      run = run && q.enq_valid[i] && q.enq_class_flat[2*i +: 2] != 2'd3 && KW'(i) < credit;
      ovf_d = ovf_d | (q.enq_valid[i] & ~run);
      slot = tail_q + PW'(i);
      ha = cdb_hit(q.enq_a_tag_flat[i*TAG_W +: TAG_W]);
      hb = cdb_hit(q.enq_b_tag_flat[i*TAG_W +: TAG_W]);
      if (run) begin
        ent_d[slot] = '{v: 1'b1, cls: q.enq_class_flat[2*i +: 2], opc: q.enq_opcode_flat[i*OPC_W +: OPC_W],
                        imm: q.enq_imm_flat[i*IMM_W +: IMM_W], rob: q.enq_rob_idx_flat[i*TAG_W +: TAG_W],
                        a_rdy: q.enq_a_ready[i] | ha[DATA_W], b_rdy: q.enq_b_ready[i] | hb[DATA_W],
                        a_tag: q.enq_a_tag_flat[i*TAG_W +: TAG_W], b_tag: q.enq_b_tag_flat[i*TAG_W +: TAG_W],
                        a_val: q.enq_a_ready[i] ? q.enq_a_value_flat[i*DATA_W +: DATA_W] : ha[DATA_W-1:0],
                        b_val: q.enq_b_ready[i] ? q.enq_b_value_flat[i*DATA_W +: DATA_W] : hb[DATA_W-1:0]};
        k = k + 1'b1;
      end
    end
    head_d = head_q + PW'(n);
    tail_d = tail_q + PW'(k);
    count_d = count_q + k - n;
    if (q.flush) begin
      for (int s = 0; s < DEPTH; s++) ent_d[s].v = 1'b0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      ovf_d = ovf_q;
      fxu_d = fxu_q;
      for (int f = 0; f < NUM_FXU; f++) fxu_d[f].v = 1'b0;
      lsu_d = lsu_q;
      lsu_d.v = 1'b0;
      bru_d = bru_q;
      bru_d.v = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ent_q <= '{default: '0};
      fxu_q <= '{default: '0};
      lsu_q <= '0;
      bru_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      fxu_q <= fxu_d;
      lsu_q <= lsu_d;
      bru_q <= bru_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  for (genvar i = 0; i < NUM_FXU; i++) begin : g_fxu
    assign q.fxu_valid[i] = fxu_q[i].v;
    assign q.fxu_rob_idx_flat[i*TAG_W +: TAG_W] = fxu_q[i].rob;
    assign q.fxu_opcode_flat[i*OPC_W +: OPC_W] = fxu_q[i].opc;
    assign q.fxu_imm_flat[i*IMM_W +: IMM_W] = fxu_q[i].imm;
    assign q.fxu_a_flat[i*DATA_W +: DATA_W] = fxu_q[i].a;
    assign q.fxu_b_flat[i*DATA_W +: DATA_W] = fxu_q[i].b;
  end
  assign {q.lsu_valid, q.lsu_rob_idx, q.lsu_opcode, q.lsu_imm, q.lsu_a, q.lsu_b} = lsu_q;
  assign {q.bru_valid, q.bru_rob_idx, q.bru_opcode, q.bru_imm, q.bru_a, q.bru_b} = bru_q;
  assign q.enq_credit = credit;
  assign q.count = count_q;
  assign q.overflow_err = ovf_q;
endmodule
